// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
// Optional feature macro used by the design: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_V1   = 3;

    // Address width for a register file of n entries
    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    // One write-back port as produced by a pipeline WB stage
    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_port_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the pipeline and the register file / scoreboard.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     flush;
    logic [DATA_W-1:0]        mon0_val;
    logic [DATA_W-1:0]        mon1_val;
    logic                     busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, mon0_val, mon1_val, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, mon0_val, mon1_val, busy_any
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register.
// Priority per edge: write clears, then reserve sets, then flush clears all.
// With REGFILE_BYPASS_EN, a read of an address written this cycle sees the
// post-edge busy value instead of the stale one.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 busy_any
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Next-state busy vector; a same-cycle reserve beats a clear (new producer)
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (rsv_en && rsv_addr != '0)
            busy_nxt[rsv_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // Busy register and its registered OR
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_any <= |busy_nxt;
        end
    end

    // Per-port busy lookup; register 0 is never busy
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0 &&
                    wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
                    rd_busy[i] = busy_nxt[rd_addr[i*AW +: AW]];
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with issue scoreboard and $v0/$v1 monitors.
// Register 0 reads zero and ignores writes; the highest-index write port wins.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int MON0_IDX = REG_V0,
    parameter int MON1_IDX = REG_V1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    regfile_mp_sb_if.slave bus
);

    localparam int            AW     = addr_w(NUM_REGS);
    localparam logic [AW-1:0] MON0_A = AW'(MON0_IDX);
    localparam logic [AW-1:0] MON1_A = AW'(MON1_IDX);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Array and monitor update; later ports overwrite earlier ones in program order
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            bus.mon0_val <= '0;
            bus.mon1_val <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*DATA_W +: DATA_W];
                    if (bus.wr_addr[j*AW +: AW] == MON0_A)
                        bus.mon0_val <= bus.wr_data[j*DATA_W +: DATA_W];
                    if (bus.wr_addr[j*AW +: AW] == MON1_A)
                        bus.mon1_val <= bus.wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Asynchronous read with optional same-cycle write forwarding
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_addr[i*AW +: AW] != '0)
                bus.rd_data[i*DATA_W +: DATA_W] = regs[bus.rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0 &&
                    bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])
                    bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
            end
`endif
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .rd_addr  (bus.rd_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .flush    (bus.flush),
        .rd_busy  (bus.rd_busy),
        .busy_any (bus.busy_any)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (32 x 32-bit, 2 read, 2 write ports).
module tb_regfile_mp_sb;

    logic Clk;
    logic Rst_n;

    regfile_mp_sb_if #(.DATA_W(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) bus_if ();

    regfile_mp_sb #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .MON0_IDX(2), .MON1_IDX(3)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus_if.wr_en    = '0;
        bus_if.wr_addr  = '0;
        bus_if.wr_data  = '0;
        bus_if.rsv_en   = 1'b0;
        bus_if.rsv_addr = '0;
        bus_if.flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus_if.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        bus_if.wr_en   = en;
        bus_if.wr_addr = {a1, a0};
        bus_if.wr_data = {d1, d0};
    endtask

    function automatic logic [31:0] rd0();
        return bus_if.rd_data[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return bus_if.rd_data[63:32];
    endfunction

    initial begin
        Rst_n = 1'b0;
        idle();
        bus_if.rd_addr = '0;
        repeat (2) tick();

        // Reset state
        set_rd(5'd1, 5'd31);
        check("rst_rd1", rd0(), 32'h0);
        check("rst_busy_any", 32'(bus_if.busy_any), 32'h0);
        check("rst_mon0", bus_if.mon0_val, 32'h0);
        @(negedge Clk) Rst_n = 1'b1;
        tick();

        // Fill regs 1..31 with their index, two per cycle
        for (int k = 1; k < 32; k += 2) begin
            if (k + 1 < 32) set_wr(2'b11, 5'(k), 32'(k), 5'(k + 1), 32'(k + 1));
            else            set_wr(2'b01, 5'(k), 32'(k), 5'd0, 32'h0);
            tick();
        end
        idle();
        set_rd(5'd31, 5'd17);
        check("fill_r31", rd0(), 32'd31);
        check("fill_r17", rd1(), 32'd17);
        check("fill_mon0", bus_if.mon0_val, 32'd2);
        check("fill_mon1", bus_if.mon1_val, 32'd3);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd10;
        tick();
        idle();
        check("pre_rst_busy_any", 32'(bus_if.busy_any), 32'h1);

        // Mid-cycle asynchronous reset
        #2 Rst_n = 1'b0;
        #1;
        check("mid_rst_r31", rd0(), 32'h0);
        check("mid_rst_r17", rd1(), 32'h0);
        check("mid_rst_mon0", bus_if.mon0_val, 32'h0);
        check("mid_rst_mon1", bus_if.mon1_val, 32'h0);
        check("mid_rst_busy_any", 32'(bus_if.busy_any), 32'h0);
        @(negedge Clk) Rst_n = 1'b1;
        tick();

        // Dual write collision: port 1 wins
        set_wr(2'b11, 5'd5, 32'h0000_AAAA, 5'd5, 32'h0000_5555);
        tick();
        idle();
        set_rd(5'd5, 5'd0);
        check("collide_r5", rd0(), 32'h0000_5555);

        // Zero register: write and reserve both dropped
        set_wr(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        check("zero_rd", rd0(), 32'h0);
        check("zero_busy", 32'(bus_if.rd_busy[0]), 32'h0);
        check("zero_busy_any", 32'(bus_if.busy_any), 32'h0);
        check("zero_mon0", bus_if.mon0_val, 32'h0);

        // Scoreboard: reserve, later clear
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd7;
        tick();
        idle();
        set_rd(5'd7, 5'd6);
        check("rsv7_busy", 32'(bus_if.rd_busy[0]), 32'h1);
        check("rsv7_other", 32'(bus_if.rd_busy[1]), 32'h0);
        check("rsv7_busy_any", 32'(bus_if.busy_any), 32'h1);
        tick();
        set_wr(2'b10, 5'd0, 32'h0, 5'd7, 32'h77);
        tick();
        idle();
        #1;
        check("clr7_busy", 32'(bus_if.rd_busy[0]), 32'h0);
        check("clr7_busy_any", 32'(bus_if.busy_any), 32'h0);
        check("clr7_data", rd0(), 32'h77);

        // Reserve and write same address same cycle: stays busy, data written
        set_wr(2'b01, 5'd7, 32'h78, 5'd0, 32'h0);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd7;
        tick();
        idle();
        #1;
        check("rsvwr7_busy", 32'(bus_if.rd_busy[0]), 32'h1);
        check("rsvwr7_data", rd0(), 32'h78);

        // Flush beats a same-cycle reserve
        bus_if.flush = 1'b1; bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd9;
        tick();
        idle();
        set_rd(5'd7, 5'd9);
        check("flush_busy_any", 32'(bus_if.busy_any), 32'h0);
        check("flush_busy7", 32'(bus_if.rd_busy[0]), 32'h0);
        check("flush_busy9", 32'(bus_if.rd_busy[1]), 32'h0);

        // Monitors: reg2 via port 1, reg3 via port 0
        set_wr(2'b11, 5'd3, 32'h0000_BEEF, 5'd2, 32'h0000_1234);
        #1;
        check("mon0_pre_edge", bus_if.mon0_val, 32'h0);
        tick();
        idle();
        check("mon0_post", bus_if.mon0_val, 32'h0000_1234);
        check("mon1_post", bus_if.mon1_val, 32'h0000_BEEF);

        // Bypass: reg4 holds 0x1111 and is reserved, then written with 0xCAFE
        set_wr(2'b01, 5'd4, 32'h0000_1111, 5'd0, 32'h0);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd4;
        tick();
        idle();
        set_rd(5'd4, 5'd4);
        check("byp_old_busy", 32'(bus_if.rd_busy[0]), 32'h1);
        set_wr(2'b10, 5'd0, 32'h0, 5'd4, 32'h0000_CAFE);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle", rd0(), 32'h0000_CAFE);
        check("byp_busy", 32'(bus_if.rd_busy[1]), 32'h0);
`else
        check("byp_same_cycle", rd0(), 32'h0000_1111);
        check("byp_busy", 32'(bus_if.rd_busy[1]), 32'h1);
`endif
        tick();
        idle();
        #1;
        check("byp_after_edge", rd1(), 32'h0000_CAFE);
        check("byp_after_busy", 32'(bus_if.rd_busy[0]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
